// File: rtl/cr_tcipif_pkg.sv
// Shared encodings and defaults for the tcipif register-bus initiator.
package cr_tcipif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_CNT_W       = 16;

  localparam logic ERR_NONE     = 1'b0;
  localparam logic ERR_MISALIGN = 1'b1;
  localparam logic ERR_TIMEOUT  = 1'b1;

  // Only word accesses exist on this bus; any nonzero byte offset is rejected.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/cr_tcipif_timeout_cnt.sv
// Saturating busy-cycle counter; expire is registered so it is high during
// the cycle in which the count equals TIMEOUT_CYC-1.
module cr_tcipif_timeout_cnt #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en && (cnt != '1)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Comparing the next value keeps expire aligned with the live count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      expire <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/cr_tcipif_master.sv
// tcipif initiator: one outstanding BIU access at a time, with misalignment
// rejection and a completion timeout toward the CLINT responder.
module cr_tcipif_master
  import cr_tcipif_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              biu_tcipif_req,
  input  logic [ADDR_W-1:0] biu_tcipif_addr,
  input  logic              biu_tcipif_write,
  input  logic [31:0]       biu_tcipif_wdata,
  output logic              tcipif_biu_gnt,
  output logic              tcipif_biu_rsp_vld,
  output logic [31:0]       tcipif_biu_rdata,
  output logic              tcipif_biu_err,
  output logic              tcipif_clint_sel,
  output logic [ADDR_W-1:0] tcipif_clint_addr,
  output logic              tcipif_clint_write,
  output logic [31:0]       tcipif_clint_wdata,
  input  logic              clint_tcipif_cmplt,
  input  logic [31:0]       clint_tcipif_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic              sel_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              write_nxt;
  logic [31:0]       wdata_nxt;
  logic [31:0]       rdata_nxt;
  logic              err_nxt;
  logic              cnt_clr;
  logic              cnt_en;
  logic              expire;
  logic              accept;

  assign tcipif_biu_gnt     = (state == IDLE);
  assign tcipif_biu_rsp_vld = (state == RESP);
  assign accept             = biu_tcipif_req && tcipif_biu_gnt;

  cr_tcipif_timeout_cnt #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk    (forever_cpuclk),
    .rst    (cpurst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (expire)
  );

  // Bus and response registers default to zero, so they only carry values
  // while an access is in BUSY or its response is in RESP.
  always_comb begin
    state_nxt = state;
    sel_nxt   = 1'b0;
    addr_nxt  = '0;
    write_nxt = 1'b0;
    wdata_nxt = '0;
    rdata_nxt = '0;
    err_nxt   = ERR_NONE;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          cnt_clr = 1'b1;
          if (is_misaligned(biu_tcipif_addr[1:0])) begin
            state_nxt = RESP;
            err_nxt   = ERR_MISALIGN;
          end else begin
            state_nxt = BUSY;
            sel_nxt   = 1'b1;
            addr_nxt  = biu_tcipif_addr;
            write_nxt = biu_tcipif_write;
            wdata_nxt = biu_tcipif_wdata;
          end
        end
      end

      // sel gates the responder clock, so it is held until the exact exit cycle.
      BUSY: begin
        if (clint_tcipif_cmplt) begin
          state_nxt = RESP;
          err_nxt   = ERR_NONE;
          rdata_nxt = tcipif_clint_write ? 32'h0 : clint_tcipif_rdata;
        end else begin
          cnt_en = 1'b1;
          if (expire) begin
            state_nxt = RESP;
            err_nxt   = ERR_TIMEOUT;
          end else begin
            sel_nxt   = 1'b1;
            addr_nxt  = tcipif_clint_addr;
            write_nxt = tcipif_clint_write;
            wdata_nxt = tcipif_clint_wdata;
          end
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state              <= IDLE;
      tcipif_clint_sel   <= 1'b0;
      tcipif_clint_addr  <= '0;
      tcipif_clint_write <= 1'b0;
      tcipif_clint_wdata <= '0;
      tcipif_biu_rdata   <= '0;
      tcipif_biu_err     <= 1'b0;
    end else begin
      state              <= state_nxt;
      tcipif_clint_sel   <= sel_nxt;
      tcipif_clint_addr  <= addr_nxt;
      tcipif_clint_write <= write_nxt;
      tcipif_clint_wdata <= wdata_nxt;
      tcipif_biu_rdata   <= rdata_nxt;
      tcipif_biu_err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cr_tcipif_master.sv
// Scoreboard bench for cr_tcipif_master: directed accesses, a behavioural
// responder, and a monitor that pops expected responses on every rsp_vld.
module tb_cr_tcipif_master;

  localparam int ADDR_W = 16;
  localparam int TO_CYC = 4;

  logic              forever_cpuclk = 1'b0;
  logic              cpurst = 1'b1;
  logic              biu_tcipif_req = 1'b0;
  logic [ADDR_W-1:0] biu_tcipif_addr = '0;
  logic              biu_tcipif_write = 1'b0;
  logic [31:0]       biu_tcipif_wdata = '0;
  logic              tcipif_biu_gnt;
  logic              tcipif_biu_rsp_vld;
  logic [31:0]       tcipif_biu_rdata;
  logic              tcipif_biu_err;
  logic              tcipif_clint_sel;
  logic [ADDR_W-1:0] tcipif_clint_addr;
  logic              tcipif_clint_write;
  logic [31:0]       tcipif_clint_wdata;
  logic              clint_tcipif_cmplt = 1'b0;
  logic [31:0]       clint_tcipif_rdata = '0;

  cr_tcipif_master #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TO_CYC),
    .CNT_W       (16)
  ) dut (
    .forever_cpuclk     (forever_cpuclk),
    .cpurst             (cpurst),
    .biu_tcipif_req     (biu_tcipif_req),
    .biu_tcipif_addr    (biu_tcipif_addr),
    .biu_tcipif_write   (biu_tcipif_write),
    .biu_tcipif_wdata   (biu_tcipif_wdata),
    .tcipif_biu_gnt     (tcipif_biu_gnt),
    .tcipif_biu_rsp_vld (tcipif_biu_rsp_vld),
    .tcipif_biu_rdata   (tcipif_biu_rdata),
    .tcipif_biu_err     (tcipif_biu_err),
    .tcipif_clint_sel   (tcipif_clint_sel),
    .tcipif_clint_addr  (tcipif_clint_addr),
    .tcipif_clint_write (tcipif_clint_write),
    .tcipif_clint_wdata (tcipif_clint_wdata),
    .clint_tcipif_cmplt (clint_tcipif_cmplt),
    .clint_tcipif_rdata (clint_tcipif_rdata)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int          resp_delay = 0;
  logic [31:0] resp_data  = '0;
  int          late_req   = 0;
  int          late_done  = 0;
  int          sel_seen   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder: completes on the resp_delay-th sel cycle (0 = never); a late
  // pulse is only produced while sel is low.
  always @(negedge forever_cpuclk) begin
    if (tcipif_clint_sel === 1'b1) begin
      sel_seen++;
      clint_tcipif_cmplt = (resp_delay != 0) && (sel_seen == resp_delay);
      clint_tcipif_rdata = clint_tcipif_cmplt ? resp_data : 32'h0;
    end else begin
      sel_seen = 0;
      clint_tcipif_cmplt = (late_req != late_done);
      clint_tcipif_rdata = clint_tcipif_cmplt ? 32'hBAD0_BAD0 : 32'h0;
      late_done = late_req;
    end
  end

  // Monitor: every response must match the oldest expected entry.
  always @(negedge forever_cpuclk) begin
    if (!cpurst && tcipif_biu_rsp_vld === 1'b1) begin
      rsp_t e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_rsp: got rsp_vld=1 err=%0b rdata=0x%0h, expected no response",
                 tcipif_biu_err, tcipif_biu_rdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rsp_err_rdata", 64'({tcipif_biu_err, tcipif_biu_rdata}), 64'({e.err, e.rdata}));
      end
    end
  end

  task automatic waitGnt();
    int n = 0;
    @(negedge forever_cpuclk);
    while (tcipif_biu_gnt !== 1'b1 && n < 20) begin
      @(negedge forever_cpuclk);
      n++;
    end
    checkOutput("gnt_wait", 64'(tcipif_biu_gnt), 64'd1);
  endtask

  task automatic applyStimulus(input string name, input logic [15:0] addr, input logic write,
                               input logic [31:0] wdata, input int delay, input logic [31:0] rsp_data,
                               input int exp_sel, input logic exp_err, input logic [31:0] exp_rdata);
    int   nsel = 0;
    logic stable = 1'b1;
    rsp_t e;
    waitGnt();
    resp_delay       = delay;
    resp_data        = rsp_data;
    biu_tcipif_req   = 1'b1;
    biu_tcipif_addr  = addr;
    biu_tcipif_write = write;
    biu_tcipif_wdata = wdata;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    exp_q.push_back(e);
    @(posedge forever_cpuclk);
    #1;
    biu_tcipif_req   = 1'b0;
    biu_tcipif_addr  = '0;
    biu_tcipif_write = 1'b0;
    biu_tcipif_wdata = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge forever_cpuclk);
      if (tcipif_clint_sel !== 1'b1) break;
      nsel++;
      if (tcipif_clint_addr !== addr || tcipif_clint_write !== write || tcipif_clint_wdata !== wdata)
        stable = 1'b0;
    end
    checkOutput({name, "_sel_cycles"}, 64'(nsel), 64'(exp_sel));
    if (exp_sel > 0) checkOutput({name, "_bus_stable"}, 64'(stable), 64'd1);
    checkOutput({name, "_rsp_vld"}, 64'(tcipif_biu_rsp_vld), 64'd1);
    checkOutput({name, "_bus_idle"},
                64'({tcipif_clint_sel, tcipif_clint_addr, tcipif_clint_write, tcipif_clint_wdata}), 64'd0);
    checkOutput({name, "_gnt_in_resp"}, 64'(tcipif_biu_gnt), 64'd0);
    @(negedge forever_cpuclk);
    checkOutput({name, "_gnt_after"}, 64'(tcipif_biu_gnt), 64'd1);
    checkOutput({name, "_rsp_one_cycle"}, 64'(tcipif_biu_rsp_vld), 64'd0);
    resp_delay = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic saw_rsp;
    @(negedge forever_cpuclk);
    checkOutput("reset_bus", 64'({tcipif_clint_sel, tcipif_clint_addr, tcipif_clint_write,
                                  tcipif_clint_wdata}), 64'd0);
    checkOutput("reset_rsp", 64'({tcipif_biu_rsp_vld, tcipif_biu_err, tcipif_biu_rdata}), 64'd0);
    checkOutput("reset_gnt", 64'(tcipif_biu_gnt), 64'd1);
    cpurst = 1'b0;

    applyStimulus("read", 16'h4000, 1'b0, 32'h0, 3, 32'h1234_5678, 3, 1'b0, 32'h1234_5678);
    applyStimulus("write", 16'h0000, 1'b1, 32'h0000_0001, 1, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
    applyStimulus("misalign", 16'h4002, 1'b0, 32'h0, 1, 32'h5555_5555, 0, 1'b1, 32'h0);
    applyStimulus("timeout", 16'h4008, 1'b0, 32'h0, 0, 32'h0, TO_CYC, 1'b1, 32'h0);

    @(posedge forever_cpuclk);
    #1;
    late_req++;
    saw_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge forever_cpuclk);
      if (tcipif_biu_rsp_vld === 1'b1) saw_rsp = 1'b1;
    end
    checkOutput("late_cmplt_ignored", 64'(saw_rsp), 64'd0);
    checkOutput("late_cmplt_gnt", 64'(tcipif_biu_gnt), 64'd1);

    applyStimulus("collision", 16'h400C, 1'b0, 32'h0, TO_CYC, 32'h0000_AA55, TO_CYC, 1'b0, 32'h0000_AA55);

    waitGnt();
    resp_delay       = 0;
    biu_tcipif_req   = 1'b1;
    biu_tcipif_addr  = 16'h4010;
    biu_tcipif_write = 1'b0;
    @(posedge forever_cpuclk);
    #1;
    biu_tcipif_req  = 1'b0;
    biu_tcipif_addr = '0;
    @(negedge forever_cpuclk);
    checkOutput("rst_busy1_sel", 64'(tcipif_clint_sel), 64'd1);
    @(negedge forever_cpuclk);
    checkOutput("rst_busy2_sel", 64'(tcipif_clint_sel), 64'd1);
    cpurst = 1'b1;
    #1;
    checkOutput("rst_async_sel", 64'(tcipif_clint_sel), 64'd0);
    @(negedge forever_cpuclk);
    cpurst = 1'b0;
    @(negedge forever_cpuclk);
    checkOutput("rst_no_rsp", 64'(tcipif_biu_rsp_vld), 64'd0);
    checkOutput("rst_gnt", 64'(tcipif_biu_gnt), 64'd1);

    applyStimulus("post_rst_read", 16'h4004, 1'b0, 32'h0, 2, 32'hCAFE_F00D, 2, 1'b0, 32'hCAFE_F00D);

    repeat (3) @(negedge forever_cpuclk);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
